// File: rtl/snake_tile_map.sv
// snake_tile_map: 40x30 tile-code store with a vblank-committed write queue
// and a two-clock render fetch feeding the sprite renderer.
//
// Bus handshake: the Avalon slave never stalls (no waitrequest). A write is
// taken on the clock edge where chipselect && write are high; a read returns
// readdata combinationally in the same cycle that chipselect && read are high.
module snake_tile_map #(
  parameter int COLS       = 40,
  parameter int ROWS       = 30,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [2:0]  address,
  input  logic [7:0]  writedata,
  output logic [7:0]  readdata,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  output logic [4:0]  tile_code,
  output logic [7:0]  sprite_addr,
  output logic        pix_valid,
  output logic        busy
);

  localparam int          CELLS  = COLS * ROWS;
  localparam int          PW     = $clog2(FIFO_DEPTH);
  localparam logic [5:0]  COLS_W = 6'(COLS);
  localparam logic [4:0]  ROWS_W = 5'(ROWS);
  localparam logic [PW:0] FULL_W = (PW+1)'(FIFO_DEPTH);
  localparam logic [10:0] LAST_W = 11'(CELLS - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  // Storage
  logic [4:0]  r_ram  [0:CELLS-1];
  logic [15:0] r_fifo [0:FIFO_DEPTH-1];   // {cell index[10:0], code[4:0]}

  // Registers
  state_t      r_state;
  logic [10:0] r_ptr;
  logic        r_clear_pending;
  logic [5:0]  r_col;
  logic [4:0]  r_row;
  logic [PW-1:0] r_wptr, r_rptr;
  logic [PW:0] r_count;
  logic        r_bad, r_ovf;
  logic [10:0] r_rd_addr;
  logic [7:0]  r_spr1;
  logic        r_pv1;

  // Combinational
  logic        w_wr_col, w_wr_row, w_wr_code, w_wr_ctrl;
  logic        w_bad, w_vblank, w_clr_window, w_start_clear;
  logic        w_empty, w_full, w_deq, w_enq, w_ovf_set;
  logic [10:0] w_wr_index, w_rd_index;
  logic [5:0]  w_pix_row, w_pix_col;
  logic        w_active;
  logic [15:0] w_head;
  logic        w_ram_we;
  logic [10:0] w_ram_waddr;
  logic [4:0]  w_ram_wdata;
  logic        w_unused;

  assign w_wr_col  = chipselect && write && (address == 3'd0);
  assign w_wr_row  = chipselect && write && (address == 3'd1);
  assign w_wr_code = chipselect && write && (address == 3'd2);
  assign w_wr_ctrl = chipselect && write && (address == 3'd3);

  assign w_bad        = (r_col >= COLS_W) || (r_row >= ROWS_W);
  assign w_vblank     = (vcount >= 10'd480);
  assign w_clr_window = (vcount >= 10'd480) && (vcount <= 10'd523);
  assign w_start_clear = (r_state == S_IDLE) && r_clear_pending && w_clr_window;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_W);
  // The sweep owns the RAM write port; the queue only drains in IDLE vblank.
  assign w_deq     = (r_state == S_IDLE) && !w_start_clear && w_vblank && !w_empty;
  assign w_enq     = w_wr_code && !w_bad && (!w_full || w_deq);
  assign w_ovf_set = w_wr_code && !w_bad && w_full && !w_deq;

  // row*40 + col without a multiplier
  assign w_wr_index = 11'({r_row, 5'b0}) + 11'({r_row, 3'b0}) + 11'(r_col);

  assign w_pix_row  = vcount[9:4];
  assign w_pix_col  = hcount[10:5];
  assign w_active   = (hcount < 11'd1280) && (vcount < 10'd480);
  assign w_rd_index = 11'({w_pix_row, 5'b0}) + 11'({w_pix_row, 3'b0}) + 11'(w_pix_col);

  assign w_head      = r_fifo[r_rptr];
  assign w_ram_we    = (r_state == S_CLEAR) || w_deq;
  assign w_ram_waddr = (r_state == S_CLEAR) ? r_ptr : w_head[15:5];
  assign w_ram_wdata = (r_state == S_CLEAR) ? 5'd0 : w_head[4:0];

  assign busy     = (r_state == S_CLEAR);
  assign readdata = (chipselect && read && (address == 3'd4)) ?
                    {r_ovf, r_bad, busy, 5'(r_count)} : 8'd0;

  assign w_unused = &{1'b0, writedata[7:6]};

  // Tile RAM write port (sweep zeroes or queue commits)
  always_ff @(posedge clk) begin
    if (w_ram_we) r_ram[w_ram_waddr] <= w_ram_wdata;
  end

  // Pending-write queue storage
  always_ff @(posedge clk) begin
    if (w_enq) r_fifo[r_wptr] <= {w_wr_index, writedata[4:0]};
  end

  // Bus registers, queue pointers/count and sticky status flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_col   <= '0;
      r_row   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_bad   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr_col) r_col <= writedata[5:0];
      if (w_wr_row) r_row <= writedata[4:0];
      if (w_enq) r_wptr <= r_wptr + 1'b1;
      if (w_deq) r_rptr <= r_rptr + 1'b1;
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_wr_ctrl && writedata[1]) begin
        r_bad <= 1'b0;
        r_ovf <= 1'b0;
      end else begin
        if (w_wr_code && w_bad) r_bad <= 1'b1;
        if (w_ovf_set)          r_ovf <= 1'b1;
      end
    end
  end

  // IDLE/CLEAR sequencer; a clear request always wins over its own consumption
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_ptr           <= '0;
      r_clear_pending <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_clear) begin
            r_state         <= S_CLEAR;
            r_ptr           <= '0;
            r_clear_pending <= 1'b0;
          end
        end
        S_CLEAR: begin
          r_ptr <= r_ptr + 1'b1;
          if (r_ptr == LAST_W) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_wr_ctrl && writedata[0]) r_clear_pending <= 1'b1;
    end
  end

  // Two-stage render fetch: address/beam info, then RAM data out
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_addr   <= '0;
      r_spr1      <= '0;
      r_pv1       <= 1'b0;
      tile_code   <= '0;
      sprite_addr <= '0;
      pix_valid   <= 1'b0;
    end else begin
      r_rd_addr   <= w_active ? w_rd_index : 11'd0;
      r_spr1      <= {vcount[3:0], hcount[4:1]};
      r_pv1       <= w_active;
      tile_code   <= r_pv1 ? r_ram[r_rd_addr] : 5'd0;
      sprite_addr <= r_spr1;
      pix_valid   <= r_pv1;
    end
  end

endmodule
